// File: rtl/periph_arbiter.sv
// Two-master round-robin arbiter and sequencer for the peripheral bus.
// Runs one registered access per grant, decodes chip selects, and returns read data with an ack.
module periph_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m0_rdwr,
  input  logic          m1_rdwr,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_rdwr,
  output logic          bus_en,
  output logic          cs_boot,
  output logic          cs_timer,
  output logic          cs_pwm,
  output logic          cs_spi,
  input  logic [DW-1:0] boot_din,
  input  logic [7:0]    spi_din
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_q;
  logic          grant;
  logic          winner;
  logic          sel_boot, sel_timer, sel_pwm, sel_spi;
  logic [DW-1:0] rdata_mux;

  // last_q doubles as the owner of the access in flight.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant   = 1'b1;
          winner  = (m0_req && m1_req) ? ~last_q : m1_req;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        if (last_q ? m0_req : m1_req) begin
          grant   = 1'b1;
          winner  = ~last_q;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant) last_q <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_rdwr  <= 1'b0;
    end else if (grant) begin
      bus_addr  <= winner ? m1_addr  : m0_addr;
      bus_wdata <= winner ? m1_wdata : m0_wdata;
      bus_rdwr  <= winner ? m1_rdwr  : m0_rdwr;
    end
  end

  assign sel_spi   = |bus_addr[11:7];
  assign sel_pwm   = (bus_addr[11:7] == 5'd0) && bus_addr[6];
  assign sel_timer = (bus_addr[11:6] == 6'd0) && bus_addr[5];
  assign sel_boot  = (bus_addr[11:5] == 7'd0);

  assign bus_en   = (state_q == ACCESS);
  assign cs_boot  = bus_en && sel_boot;
  assign cs_timer = bus_en && sel_timer;
  assign cs_pwm   = bus_en && sel_pwm;
  assign cs_spi   = bus_en && sel_spi;

  assign rdata_mux = sel_spi ? {{(DW-8){1'b0}}, spi_din} : boot_din;

  // Peripheral data is taken at the edge that enters DONE so rdata lands together with the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= (state_q == ACCESS) && !last_q;
      m1_ack <= (state_q == ACCESS) && last_q;
      if ((state_q == ACCESS) && !last_q) m0_rdata <= rdata_mux;
      if ((state_q == ACCESS) && last_q)  m1_rdata <= rdata_mux;
    end
  end

endmodule

// File: tb/tb_periph_arbiter.sv
// Scoreboard bench for periph_arbiter: stimulus queues expected bus cycles and acks,
// a monitor pops and compares them whenever the DUT strobes bus_en or an ack.
module tb_periph_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_rdwr = 1'b0, m1_rdwr = 1'b0;
  logic [DW-1:0] boot_din = '0;
  logic [7:0]    spi_din = '0;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_rdwr, bus_en;
  logic          cs_boot, cs_timer, cs_pwm, cs_spi;

  periph_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdwr(m0_rdwr), .m1_rdwr(m1_rdwr),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdwr(bus_rdwr), .bus_en(bus_en),
    .cs_boot(cs_boot), .cs_timer(cs_timer), .cs_pwm(cs_pwm), .cs_spi(cs_spi),
    .boot_din(boot_din), .spi_din(spi_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        rdwr;
    logic [3:0]  cs;
    logic [31:0] cyc;
  } bus_exp_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic        chk_data;
    logic [31:0] cyc;
  } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack0_q[$];
  ack_exp_t ack1_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   timeouts = 0;
  logic end_req = 1'b0;
  bus_exp_t be;
  ack_exp_t ae;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: reset values while rst_n is low, otherwise pop and compare on every strobe.
  always begin
    @(negedge clk or negedge rst_n);
    if (rst_n !== 1'b1) begin
      #1;
      checkOutput("rst_bus_en", 32'(bus_en), 32'h0);
      checkOutput("rst_cs", 32'({cs_boot, cs_timer, cs_pwm, cs_spi}), 32'h0);
      checkOutput("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
      checkOutput("rst_bus_addr", 32'(bus_addr), 32'h0);
      checkOutput("rst_bus_wdata", 32'(bus_wdata), 32'h0);
      checkOutput("rst_bus_rdwr", 32'(bus_rdwr), 32'h0);
      checkOutput("rst_m0_rdata", 32'(m0_rdata), 32'h0);
      checkOutput("rst_m1_rdata", 32'(m1_rdata), 32'h0);
    end else begin
      if (bus_en === 1'b1) begin
        checkOutput("bus_expected", 32'(bus_q.size() != 0), 32'h1);
        if (bus_q.size() != 0) begin
          be = bus_q.pop_front();
          checkOutput("bus_addr", 32'(bus_addr), 32'(be.addr));
          checkOutput("bus_wdata", 32'(bus_wdata), 32'(be.wdata));
          checkOutput("bus_rdwr", 32'(bus_rdwr), 32'(be.rdwr));
          checkOutput("bus_cs", 32'({cs_boot, cs_timer, cs_pwm, cs_spi}), 32'(be.cs));
          checkOutput("bus_cycle", 32'(cyc), be.cyc);
        end
      end
      if (m0_ack === 1'b1) begin
        checkOutput("m0_ack_expected", 32'(ack0_q.size() != 0), 32'h1);
        if (ack0_q.size() != 0) begin
          ae = ack0_q.pop_front();
          if (ae.chk_data) checkOutput("m0_rdata", 32'(m0_rdata), 32'(ae.rdata));
          checkOutput("m0_ack_cycle", 32'(cyc), ae.cyc);
        end
      end
      if (m1_ack === 1'b1) begin
        checkOutput("m1_ack_expected", 32'(ack1_q.size() != 0), 32'h1);
        if (ack1_q.size() != 0) begin
          ae = ack1_q.pop_front();
          if (ae.chk_data) checkOutput("m1_rdata", 32'(m1_rdata), 32'(ae.rdata));
          checkOutput("m1_ack_cycle", 32'(cyc), ae.cyc);
        end
      end
      if (end_req) begin
        checkOutput("bus_q_drained", 32'(bus_q.size()), 32'h0);
        checkOutput("ack0_q_drained", 32'(ack0_q.size()), 32'h0);
        checkOutput("ack1_q_drained", 32'(ack1_q.size()), 32'h0);
        checkOutput("ack_timeouts", 32'(timeouts), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bus(input logic [11:0] a, input logic [15:0] d, input logic rw,
                            input logic [3:0] cs, input int c);
    bus_q.push_back('{addr: a, wdata: d, rdwr: rw, cs: cs, cyc: 32'(c)});
  endtask

  task automatic expect_ack(input int m, input logic [15:0] rd, input logic chk, input int c);
    if (m == 0) ack0_q.push_back('{rdata: rd, chk_data: chk, cyc: 32'(c)});
    else        ack1_q.push_back('{rdata: rd, chk_data: chk, cyc: 32'(c)});
  endtask

  task automatic applyStimulus(input int m, input logic [11:0] a, input logic [15:0] d,
                               input logic rw);
    if (m == 0) begin
      m0_addr = a; m0_wdata = d; m0_rdwr = rw; m0_req = 1'b1;
    end else begin
      m1_addr = a; m1_wdata = d; m1_rdwr = rw; m1_req = 1'b1;
    end
  endtask

  // Holds the request until n acks have been seen, then drops it.
  task automatic wait_ack(input int m, input int n);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 40) begin
      @(negedge clk);
      budget++;
      if ((m == 0 && m0_ack === 1'b1) || (m == 1 && m1_ack === 1'b1)) got++;
    end
    if (got < n) begin
      timeouts++;
      $display("[TB] FAIL ack_wait_m%0d: got %0d acks, expected %0d", m, got, n);
    end
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  initial begin
    int k;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    $display("[TB] m0 read from bootrom");
    boot_din = 16'hA55A;
    tick(); k = cyc;
    expect_bus(12'h005, 16'h0000, 1'b0, 4'b1000, k + 1);
    expect_ack(0, 16'hA55A, 1'b1, k + 2);
    applyStimulus(0, 12'h005, 16'h0000, 1'b0);
    wait_ack(0, 1);

    $display("[TB] m1 write to timer");
    tick(); k = cyc;
    expect_bus(12'h020, 16'h0003, 1'b1, 4'b0100, k + 1);
    expect_ack(1, 16'h0000, 1'b0, k + 2);
    applyStimulus(1, 12'h020, 16'h0003, 1'b1);
    wait_ack(1, 1);

    $display("[TB] simultaneous requests, pwm and spi reads");
    boot_din = 16'h1234;
    spi_din  = 8'h7E;
    tick(); k = cyc;
    expect_bus(12'h040, 16'h0000, 1'b0, 4'b0010, k + 1);
    expect_bus(12'h080, 16'h0000, 1'b0, 4'b0001, k + 3);
    expect_ack(0, 16'h1234, 1'b1, k + 2);
    expect_ack(1, 16'h007E, 1'b1, k + 4);
    applyStimulus(0, 12'h040, 16'h0000, 1'b0);
    applyStimulus(1, 12'h080, 16'h0000, 1'b0);
    fork
      wait_ack(0, 1);
      wait_ack(1, 1);
    join

    $display("[TB] both requests held, alternating grants");
    boot_din = 16'hBEEF;
    spi_din  = 8'h5C;
    tick(); k = cyc;
    expect_bus(12'h01F, 16'h0000, 1'b0, 4'b1000, k + 1);
    expect_bus(12'hFFF, 16'h0000, 1'b0, 4'b0001, k + 3);
    expect_bus(12'h01F, 16'h0000, 1'b0, 4'b1000, k + 5);
    expect_bus(12'hFFF, 16'h0000, 1'b0, 4'b0001, k + 7);
    expect_ack(0, 16'hBEEF, 1'b1, k + 2);
    expect_ack(1, 16'h005C, 1'b1, k + 4);
    expect_ack(0, 16'hBEEF, 1'b1, k + 6);
    expect_ack(1, 16'h005C, 1'b1, k + 8);
    applyStimulus(0, 12'h01F, 16'h0000, 1'b0);
    applyStimulus(1, 12'hFFF, 16'h0000, 1'b0);
    fork
      wait_ack(0, 2);
      wait_ack(1, 2);
    join

    $display("[TB] decode edges for timer and pwm");
    boot_din = 16'h3F3F;
    tick(); k = cyc;
    expect_bus(12'h03F, 16'h0000, 1'b0, 4'b0100, k + 1);
    expect_ack(1, 16'h3F3F, 1'b1, k + 2);
    applyStimulus(1, 12'h03F, 16'h0000, 1'b0);
    wait_ack(1, 1);
    boot_din = 16'h7F7F;
    tick(); k = cyc;
    expect_bus(12'h07F, 16'h0000, 1'b0, 4'b0010, k + 1);
    expect_ack(1, 16'h7F7F, 1'b1, k + 2);
    applyStimulus(1, 12'h07F, 16'h0000, 1'b0);
    wait_ack(1, 1);

    $display("[TB] reset asserted during ACCESS");
    boot_din = 16'h0F0F;
    tick(); k = cyc;
    expect_bus(12'h005, 16'h0000, 1'b0, 4'b1000, k + 1);
    applyStimulus(0, 12'h005, 16'h0000, 1'b0);
    @(posedge clk);
    #7 rst_n = 1'b0;
    expect_bus(12'h005, 16'h0000, 1'b0, 4'b1000, k + 3);
    expect_ack(0, 16'h0F0F, 1'b1, k + 4);
    #10 rst_n = 1'b1;
    wait_ack(0, 1);

    repeat (3) tick();
    end_req = 1'b1;
    repeat (10) @(posedge clk);
    $display("[TB] FAIL summary_not_reached: monitor still running, expected finish");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule
